// File: rtl/ifmap_bus_feeder.sv
// Streams one ifmap row from the global buffer onto a PE column's feature bus.
// Define GIN_ZERO_PAD_EN to add leading/trailing zero padding to each row.
module ifmap_bus_feeder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned NUM_PE     = 12,
    parameter int unsigned PARA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [ID_WIDTH-1:0]   row_id,
    input  logic [NUM_PE-1:0]     dest_mask,
`ifdef GIN_ZERO_PAD_EN
    input  logic [PARA_WIDTH-1:0] pad,
`endif
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_PE-1:0]     pe_ready,
    output logic [ID_WIDTH-1:0]   bus_feature_id,
    output logic [DATA_WIDTH-1:0] bus_feature_in,
    output logic                  bus_feature_valid,
    output logic                  busy,
    output logic                  done
);

    // Beat counter must hold len + 2*pad.
    localparam int unsigned CntW = ((ADDR_WIDTH > PARA_WIDTH) ? ADDR_WIDTH : PARA_WIDTH) + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, len_q, rd_issued_q;
    logic [ID_WIDTH-1:0]   row_id_q;
    logic [NUM_PE-1:0]     mask_q;
    logic [CntW-1:0]       sent_q;
`ifdef GIN_ZERO_PAD_EN
    logic [PARA_WIDTH-1:0] pad_q;
`endif

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wr_ptr_q, rd_ptr_q, inflight_q;
    logic [1:0]            count_q;

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ID_WIDTH-1:0]   fid_q;

    logic [CntW-1:0] pad_w, pad_in_w, len_w, total, total_in;
    logic            in_run, gate, beats_left, zero_beat, go, pop;
    logic [2:0]      occ_after;

    always_comb begin
`ifdef GIN_ZERO_PAD_EN
        pad_w    = CntW'(pad_q);
        pad_in_w = CntW'(pad);
`else
        pad_w    = '0;
        pad_in_w = '0;
`endif
        len_w      = CntW'(len_q);
        total      = len_w + (pad_w << 1);
        total_in   = CntW'(len) + (pad_in_w << 1);
        in_run     = (state_q == StRun);
        gate       = &(pe_ready | ~mask_q);
        beats_left = (sent_q != total);
        zero_beat  = (sent_q < pad_w) || (sent_q >= (pad_w + len_w));
        go         = in_run && beats_left && gate && (zero_beat || (count_q != 2'd0));
        pop        = go && !zero_beat;
        // Occupancy is taken after this cycle's pop so a steady stream needs no bubble.
        occ_after  = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};
        rd_en      = in_run && (rd_issued_q < len_q) && (occ_after < 3'd2);
        rd_addr    = base_q + rd_issued_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = (total_in == '0) ? StDone : StRun;
            StRun:  if (!beats_left) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            row_id_q    <= '0;
            mask_q      <= '0;
            rd_issued_q <= '0;
            sent_q      <= '0;
`ifdef GIN_ZERO_PAD_EN
            pad_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                base_q      <= base_addr;
                len_q       <= len;
                row_id_q    <= row_id;
                mask_q      <= dest_mask;
                rd_issued_q <= '0;
                sent_q      <= '0;
`ifdef GIN_ZERO_PAD_EN
                pad_q       <= pad;
`endif
            end else begin
                if (rd_en) rd_issued_q <= rd_issued_q + 1'b1;
                if (go)    sent_q      <= sent_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= rd_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            fid_q   <= '0;
        end else begin
            valid_q <= go;
            if (go) begin
                data_q <= zero_beat ? '0 : buf_q[rd_ptr_q];
                fid_q  <= row_id_q;
            end
        end
    end

    assign bus_feature_valid = valid_q;
    assign bus_feature_in    = data_q;
    assign bus_feature_id    = fid_q;
    assign busy              = (state_q != StIdle);
    assign done              = (state_q == StDone);

endmodule

// File: tb/tb_ifmap_bus_feeder.sv
// Self-checking bench for ifmap_bus_feeder: directed table, hand-written reset case and
// random rows, all checked against a row-level reference model and an SRAM model.
module tb_ifmap_bus_feeder;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int IW = 8;
    localparam int NP = 12;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len = '0;
    logic [IW-1:0] row_id = '0;
    logic [NP-1:0] dest_mask = '0;
    logic [NP-1:0] pe_ready = '0;
`ifdef GIN_ZERO_PAD_EN
    logic [PW-1:0] pad = '0;
`endif
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [IW-1:0] bus_feature_id;
    logic [DW-1:0] bus_feature_in;
    logic          bus_feature_valid;
    logic          busy;
    logic          done;

    ifmap_bus_feeder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .len               (len),
        .row_id            (row_id),
        .dest_mask         (dest_mask),
`ifdef GIN_ZERO_PAD_EN
        .pad               (pad),
`endif
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .pe_ready          (pe_ready),
        .bus_feature_id    (bus_feature_id),
        .bus_feature_in    (bus_feature_in),
        .bus_feature_valid (bus_feature_valid),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Global buffer model: one-cycle read latency, junk when not read.
    logic [DW-1:0] mem [256];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : DW'($urandom);

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: records beats, reads, done pulses and busy cycles.
    int            beat_data_q[$];
    int            beat_id_q[$];
    int            beat_cyc_q[$];
    int            rd_addr_q[$];
    int            done_cyc_q[$];
    int            busy_cycles = 0;
    logic          gate_prev = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic [IW-1:0] last_id = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            gate_prev <= 1'b0;
            last_data <= '0;
            last_id   <= '0;
        end else begin
            if (bus_feature_valid) begin
                check("beat_after_ready", gate_prev, 1);
                beat_data_q.push_back(int'(bus_feature_in));
                beat_id_q.push_back(int'(bus_feature_id));
                beat_cyc_q.push_back(cyc);
            end else begin
                check("hold_data", bus_feature_in, last_data);
                check("hold_id", bus_feature_id, last_id);
            end
            if (rd_en) rd_addr_q.push_back(int'(rd_addr));
            if (done) done_cyc_q.push_back(cyc);
            if (busy) busy_cycles <= busy_cycles + 1;
            gate_prev <= &(pe_ready | ~dest_mask);
            last_data <= bus_feature_in;
            last_id   <= bus_feature_id;
        end
    end

    // mode: 0 all ready, 1 random ready, 2 pe_ready[2] low in cycles 5..8 after start.
    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic [IW-1:0] id;
        logic [NP-1:0] mask;
        logic [PW-1:0] pad;
        int            mode;
        bit            repulse;
        int            exp_beats;
        int            exp_lat;   // first beat edges after accepting edge, -1 = don't care
        bit            b2b;
    } row_t;

    task automatic run_row(input row_t r, input string tag);
        int            s, acc, p, nb, nd, nr, b0, r0, d0, bc0, lowcnt, quietcnt;
        int            exp_d[$];
        bit            finished;
        logic [AW-1:0] a;
`ifdef GIN_ZERO_PAD_EN
        p = int'(r.pad);
`else
        p = 0;
`endif
        // Reference row: pad zeros, len buffer words from base (wrapping), pad zeros.
        for (int i = 0; i < p; i++) exp_d.push_back(0);
        for (int i = 0; i < int'(r.len); i++) begin
            a = r.base + AW'(i);
            exp_d.push_back(int'(mem[a]));
        end
        for (int i = 0; i < p; i++) exp_d.push_back(0);

        b0  = beat_data_q.size();
        r0  = rd_addr_q.size();
        d0  = done_cyc_q.size();
        bc0 = busy_cycles;

        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = r.base;
        len       = r.len;
        row_id    = r.id;
        dest_mask = r.mask;
`ifdef GIN_ZERO_PAD_EN
        pad       = r.pad;
`endif
        pe_ready  = (r.mode == 1) ? NP'($urandom) : '1;
        s   = cyc;
        acc = s + 1;
        finished = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (r.repulse && cyc == s + 3) begin
                start     = 1'b1;
                base_addr = 8'h40;
                len       = 8'd9;
                row_id    = ~r.id;
            end
            case (r.mode)
                1: pe_ready = ($urandom_range(0, 9) < 6) ? '1 : NP'($urandom);
                2: begin
                    pe_ready = '1;
                    if (cyc >= s + 5 && cyc <= s + 8) pe_ready[2] = 1'b0;
                end
                default: pe_ready = '1;
            endcase
            if (done_cyc_q.size() > d0) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, " done_seen"}, finished, 1);
        repeat (3) @(posedge clk);
        #1;
        if (!finished) return;

        nb = beat_data_q.size() - b0;
        nr = rd_addr_q.size() - r0;
        nd = done_cyc_q.size() - d0;
        check({tag, " beat_count"}, nb, exp_d.size());
        check({tag, " beat_count_table"}, nb, r.exp_beats);
        for (int i = 0; i < nb && i < exp_d.size(); i++) begin
            check({tag, " beat_data"}, beat_data_q[b0 + i], exp_d[i]);
            check({tag, " beat_id"}, beat_id_q[b0 + i], int'(r.id));
        end
        check({tag, " read_count"}, nr, int'(r.len));
        for (int i = 0; i < nr && i < int'(r.len); i++) begin
            a = r.base + AW'(i);
            check({tag, " rd_addr"}, rd_addr_q[r0 + i], int'(a));
        end
        check({tag, " done_pulses"}, nd, 1);
        if (nb > 0) check({tag, " done_after_last"}, done_cyc_q[d0], beat_cyc_q[b0 + nb - 1] + 1);
        else        check({tag, " done_latency"}, done_cyc_q[d0], acc);
        check({tag, " busy_cycles"}, busy_cycles - bc0, done_cyc_q[d0] - acc + 1);
        if (r.exp_lat >= 0 && nb > 0)
            check({tag, " first_beat_lat"}, beat_cyc_q[b0] - acc, r.exp_lat);
        if (r.b2b && nb > 0)
            check({tag, " back_to_back"}, beat_cyc_q[b0 + nb - 1] - beat_cyc_q[b0], nb - 1);
        if (r.mode == 2 && r.mask[2]) begin
            lowcnt   = 0;
            quietcnt = 0;
            for (int i = 0; i < nb; i++) begin
                if (beat_cyc_q[b0 + i] >= s + 5 && beat_cyc_q[b0 + i] <= s + 8) lowcnt++;
                if (beat_cyc_q[b0 + i] >= s + 6 && beat_cyc_q[b0 + i] <= s + 9) quietcnt++;
            end
            check({tag, " beats_while_low_le1"}, lowcnt <= 1, 1);
            check({tag, " no_beats_after_low"}, quietcnt, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    row_t vec[$];
    row_t rr;

    initial begin
        int b0, d0;
        bit  got;
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(1, 65535));

        vec.push_back('{8'h10, 8'd4, 8'h11, '1, 8'd0, 0, 1'b0, 4, 3, 1'b1});
        vec.push_back('{8'h30, 8'd6, 8'h22, '1, 8'd0, 2, 1'b0, 6, -1, 1'b0});
        vec.push_back('{8'h30, 8'd6, 8'h23, 12'hFFB, 8'd0, 2, 1'b0, 6, 3, 1'b1});
        vec.push_back('{8'h50, 8'd0, 8'h33, '1, 8'd0, 0, 1'b0, 0, -1, 1'b0});
        vec.push_back('{8'hFE, 8'd4, 8'h44, '1, 8'd0, 0, 1'b1, 4, 3, 1'b1});
        vec.push_back('{8'h80, 8'd1, 8'h55, 12'h000, 8'd0, 1, 1'b0, 1, 3, 1'b1});
        vec.push_back('{8'hF0, 8'd20, 8'h66, 12'h5A5, 8'd0, 1, 1'b0, 20, -1, 1'b0});
`ifdef GIN_ZERO_PAD_EN
        vec.push_back('{8'h08, 8'd3, 8'h77, '1, 8'd2, 0, 1'b0, 7, -1, 1'b0});
        vec.push_back('{8'h08, 8'd0, 8'h78, '1, 8'd3, 0, 1'b0, 6, -1, 1'b0});
`endif

        // Reset state.
        #1;
        check("reset_valid", bus_feature_valid, 0);
        check("reset_data", bus_feature_in, 0);
        check("reset_id", bus_feature_id, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", rd_en, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vec[i]) run_row(vec[i], $sformatf("vec%0d", i));

        // Reset in the middle of a row: outputs clear at once and the row is dropped.
        b0 = beat_data_q.size();
        d0 = done_cyc_q.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h20; len = 8'd8; row_id = 8'h99; dest_mask = '1;
        pe_ready = '1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (beat_data_q.size() >= b0 + 2) begin
                got = 1'b1;
                break;
            end
        end
        check("midrow_two_beats", got, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrow_rst_valid", bus_feature_valid, 0);
        check("midrow_rst_data", bus_feature_in, 0);
        check("midrow_rst_id", bus_feature_id, 0);
        check("midrow_rst_busy", busy, 0);
        check("midrow_rst_rd_en", rd_en, 0);
        check("midrow_rst_rd_addr", rd_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrow_no_done", done_cyc_q.size(), d0);
        run_row('{8'h20, 8'd5, 8'h9A, '1, 8'd0, 0, 1'b0, 5, 3, 1'b1}, "after_reset");

        // Random rows.
        for (int n = 0; n < 25; n++) begin
            rr.base    = AW'($urandom);
            rr.len     = AW'($urandom_range(0, 15));
            rr.id      = IW'($urandom);
            rr.mask    = ($urandom_range(0, 3) == 0) ? '0 : NP'($urandom);
`ifdef GIN_ZERO_PAD_EN
            rr.pad     = PW'($urandom_range(0, 3));
`else
            rr.pad     = '0;
`endif
            rr.mode    = 1;
            rr.repulse = ($urandom_range(0, 3) == 0);
            rr.exp_beats = int'(rr.len) + 2 * int'(rr.pad);
            rr.exp_lat = -1;
            rr.b2b     = 1'b0;
            run_row(rr, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
